// File: rtl/mem_wb_stage.sv
// MEM stage + MEM/WB register: word/half/byte loads/stores on local RAM; WAIT_STATES+1 cycle access latency.
// Backpressure: Stall (combinational) holds EX/MEM for WAIT_STATES cycles per aligned access; bubbles fill MEM/WB meanwhile.
module mem_wb_stage #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] in_ALU_out,
  input  logic [31:0] in_ReadData_2,
  input  logic [4:0]  in_dest_reg,
  input  logic        in_MemWrite,
  input  logic        in_MemRead,
  input  logic        in_MemToReg,
  input  logic        in_RegWrite,
  input  logic [1:0]  in_MemSize,
  input  logic        in_MemSigned,
  output logic        Stall,
  output logic [31:0] out_ReadData,
  output logic [31:0] out_ALU_out,
  output logic [4:0]  out_dest_reg,
  output logic        out_MemToReg,
  output logic        out_RegWrite,
  output logic        out_Misaligned
);

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t               state, state_nxt;
  logic [2:0]           cnt, cnt_nxt;
  logic [31:0]          mem [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] word_idx;
  logic [1:0]           byte_off;
  logic                 is_half, is_byte, is_access, misaligned, aligned_access;
  logic                 complete, stall_c, do_write;
  logic [31:0]          rd_word, ld_data, st_data;
  logic [3:0]           st_be;
  logic [15:0]          half_sel;
  logic [7:0]           byte_sel;
  logic                 unused_addr_bits;

  // Upper address bits are ignored so accesses alias within the RAM.
  assign word_idx         = in_ALU_out[ADDR_BITS+1:2];
  assign byte_off         = in_ALU_out[1:0];
  assign unused_addr_bits = ^in_ALU_out[31:ADDR_BITS+2];

  assign is_half        = (in_MemSize == 2'b01);
  assign is_byte        = (in_MemSize == 2'b10);
  assign is_access      = in_MemRead | in_MemWrite;
  assign misaligned     = is_access & ((is_half & byte_off[0]) |
                                       (!is_half & !is_byte & (byte_off != 2'b00)));
  assign aligned_access = is_access & !misaligned;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_c   = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (aligned_access) begin
          if (WS == 3'd0) begin
            complete = 1'b1;
          end else begin
            stall_c   = 1'b1;
            state_nxt = WAIT;
            cnt_nxt   = 3'd1;
          end
        end
      end
      WAIT: begin
        if (cnt == WS) begin
          complete  = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = 3'd0;
        end else begin
          stall_c = 1'b1;
          cnt_nxt = cnt + 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign Stall = Reset & stall_c;

  // Reset on the completing edge must suppress the commit.
  assign do_write = Reset & complete & in_MemWrite;

  always_comb begin
    st_data = in_ReadData_2;
    st_be   = 4'b1111;
    if (is_byte) begin
      st_data = {4{in_ReadData_2[7:0]}};
      st_be   = 4'b0001 << byte_off;
    end else if (is_half) begin
      st_data = {2{in_ReadData_2[15:0]}};
      st_be   = byte_off[1] ? 4'b1100 : 4'b0011;
    end
  end

  always_ff @(posedge Clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem[word_idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    rd_word  = mem[word_idx];
    half_sel = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
    case (byte_off)
      2'd0:    byte_sel = rd_word[7:0];
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    if (is_byte)      ld_data = {{24{in_MemSigned & byte_sel[7]}}, byte_sel};
    else if (is_half) ld_data = {{16{in_MemSigned & half_sel[15]}}, half_sel};
    else              ld_data = rd_word;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      out_ReadData   <= 32'd0;
      out_ALU_out    <= 32'd0;
      out_dest_reg   <= 5'd0;
      out_MemToReg   <= 1'b0;
      out_RegWrite   <= 1'b0;
      out_Misaligned <= 1'b0;
    end else if (state == IDLE && !aligned_access) begin
      out_ReadData   <= 32'd0;
      out_ALU_out    <= in_ALU_out;
      out_dest_reg   <= in_dest_reg;
      out_MemToReg   <= in_MemToReg;
      out_RegWrite   <= in_RegWrite & !misaligned;
      out_Misaligned <= misaligned;
    end else if (complete) begin
      out_ReadData   <= in_MemWrite ? 32'd0 : ld_data;
      out_ALU_out    <= in_ALU_out;
      out_dest_reg   <= in_dest_reg;
      out_MemToReg   <= in_MemToReg;
      out_RegWrite   <= in_RegWrite;
      out_Misaligned <= 1'b0;
    end else begin
      out_ReadData   <= 32'd0;
      out_ALU_out    <= 32'd0;
      out_dest_reg   <= 5'd0;
      out_MemToReg   <= 1'b0;
      out_RegWrite   <= 1'b0;
      out_Misaligned <= 1'b0;
    end
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register of the pipelined MIPS datapath.
- Consumes EX/MEM register outputs (ALU result/address, store data, destination register, control bits) and performs word/half/byte loads and stores on an internal data memory with configurable wait states.
- Drives a pipeline Stall and presents registered write-back values to the register-file write port and MemToReg mux.

Parameters:
- ADDR_BITS, 10, word-address width; memory holds 2^ADDR_BITS 32-bit words.
- WAIT_STATES, 2, extra cycles per memory access (legal 0..7).

Ports:
- Clk  in  1  pipeline clock (divided clock domain).
- Reset  in  1  synchronous, active-low reset.
- in_ALU_out  in  32  byte address for loads/stores, or ALU result for pass-through.
- in_ReadData_2  in  32  store data.
- in_dest_reg  in  5  write-back register number.
- in_MemWrite  in  1  store request.
- in_MemRead  in  1  load request.
- in_MemToReg  in  1  write-back select.
- in_RegWrite  in  1  write-back enable.
- in_MemSize  in  2  00 word, 01 half, 10 byte, 11 treated as word.
- in_MemSigned  in  1  1 = sign-extend half/byte loads, 0 = zero-extend.
- Stall  out  1  combinational; 1 = upstream must hold EX/MEM contents.
- out_ReadData  out  32  registered load data.
- out_ALU_out  out  32  registered ALU result.
- out_dest_reg  out  5  registered destination register.
- out_MemToReg  out  1  registered.
- out_RegWrite  out  1  registered.
- out_Misaligned  out  1  registered one-cycle fault flag.

Behaviour:
- Reset (Reset=0 at posedge Clk) clears all out_* to 0, FSM to IDLE, and wait counter to 0. Stall=0 while Reset=0. Memory contents are not cleared.
- Addressing: word index = in_ALU_out[ADDR_BITS+1:2]; higher bits are ignored, so addresses wrap. Little-endian lanes: byte offset 0 = bits 7:0; half offset 0 = bits 15:0.
- Alignment:
  - word access requires addr[1:0]=00; half access requires addr[0]=0.
  - A misaligned access performs no read or write and does not stall. The next edge registers out_Misaligned=1, out_RegWrite=0, and the other fields normally.
- Non-memory op (MemRead=MemWrite=0): passes through with 1-cycle latency; out_ReadData=0; Stall=0.
- If MemRead and MemWrite are both 1, the access is a write; out_RegWrite follows the input.
- FSM states IDLE and WAIT:
  - IDLE with an aligned access and WAIT_STATES=0: access completes at the next edge with 1-cycle latency and no stall.
  - IDLE with an aligned access and WAIT_STATES>0: Stall=1 combinationally; the next edge moves to WAIT with counter=1 and loads a bubble into MEM/WB (out_RegWrite=0, out_MemToReg=0, other fields 0).
  - WAIT: Stall=1 while counter<WAIT_STATES. Each edge increments the counter and loads a bubble.
  - WAIT with counter==WAIT_STATES: Stall=0. At that edge the store commits with byte enables (sb/sh touch only the addressed lanes), or load data is extended and registered. MEM/WB captures the real values and the FSM returns to IDLE.
  - Total access latency is WAIT_STATES+1 cycles. Stall is high for WAIT_STATES cycles.
- Inputs are sampled only in IDLE and at the completing edge; upstream holds them constant while Stall=1.
- Load-after-store to the same word in back-to-back accesses returns the new data, because the write committed at the earlier edge.
- Reset during WAIT aborts the access: no memory write occurs, including when Reset=0 coincides with the completing edge.
- out_Misaligned is high for exactly one cycle per faulting instruction.

Test Plan:
- WAIT_STATES=2: sw 0xDEADBEEF to 0x10, then lw 0x10 -> each access has Stall high 2 cycles, bubbles during the stall, out_ReadData=0xDEADBEEF with out_RegWrite=1 on the completing cycle.
- Byte and half loads/stores:
  - sb 0x80 to 0x13, then lb 0x13 -> 0xFFFFFF80; lbu 0x13 -> 0x00000080; lw 0x10 -> 0x80ADBEEF.
  - sh 0x1234 to 0x12, then lh 0x12 -> 0x00001234.
- Misaligned accesses: lw 0x11 and sh 0x21 -> no stall, out_Misaligned=1 for one cycle, out_RegWrite=0, memory unchanged (verified by later lw).
- Pass-through: add result 0x7, dest 5, RegWrite=1 -> next cycle out_ALU_out=7, out_dest_reg=5, out_RegWrite=1, Stall never asserted.
- Reset mid-access: sw 0xCAFEF00D to 0x40, drive Reset=0 in the second stall cycle -> outputs 0, Stall 0, subsequent lw 0x40 returns the prior value.
- Address wrap and zero-wait: address 0x1000 with ADDR_BITS=10 aliases to 0x0. With WAIT_STATES=0, back-to-back sw/lw complete with 1-cycle latency and no Stall.
